// File: rtl/fence_flush_sequencer.sv
// FENCE / FENCE.I side-effect sequencer: store-buffer drain, D$ flush handshake, I$ flush, then refetch.
// Optional D$ ack watchdog enabled by defining FENCE_SEQ_TIMEOUT_EN.
module fence_flush_sequencer #(
  parameter bit          SKIP_DCACHE_FLUSH = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fence_i,
  input  logic fence_i_i,
  input  logic kill_i,
  input  logic sb_empty_i,
  output logic flush_dcache_o,
  input  logic flush_dcache_ack_i,
  output logic flush_icache_o,
  output logic set_pc_commit_o,
  output logic flush_pipe_o,
  output logic halt_o,
  output logic busy_o,
  output logic timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_DFLUSH,
    S_IFLUSH,
    S_DONE
  } state_e;

  typedef struct packed {
    logic halt;
    logic busy;
    logic flush_dcache;
    logic flush_icache;
    logic set_pc;
    logic flush_pipe;
  } outs_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fence_flush_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  // Outputs are registered alongside the state, so each transition loads the
  // output pattern of the state it enters.
  function automatic outs_t decode(input state_e s);
    outs_t o;
    o              = '0;
    o.busy         = (s != S_IDLE);
    o.halt         = (s != S_IDLE);
    o.flush_dcache = (s == S_DFLUSH);
    o.flush_icache = (s == S_IFLUSH);
    o.set_pc       = (s == S_DONE);
    o.flush_pipe   = (s == S_DONE);
    return o;
  endfunction

  state_e state_q;
  outs_t  out_q;
  logic   is_fencei_q;
  logic   kill_q;

`ifdef FENCE_SEQ_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  state_e           to_exit;
`endif

  logic   kill_any;
  state_e drain_exit;
  state_e ack_exit;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    kill_any   = kill_q | kill_i;
    drain_exit = S_DFLUSH;
    if (SKIP_DCACHE_FLUSH) drain_exit = is_fencei_q ? S_IFLUSH : S_DONE;
    ack_exit   = kill_any ? S_IDLE : (is_fencei_q ? S_IFLUSH : S_DONE);
`ifdef FENCE_SEQ_TIMEOUT_EN
    to_exit    = kill_any ? S_IDLE : S_DONE;
`endif
  end

  // NOTE: state and output flops use non-blocking assignments only; the reset
  // clears every output register so outputs drop as soon as rst_i rises.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      is_fencei_q <= 1'b0;
      kill_q      <= 1'b0;
`ifdef FENCE_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fence_i || fence_i_i) begin
            state_q     <= S_DRAIN;
            out_q       <= decode(S_DRAIN);
            is_fencei_q <= fence_i_i;
            kill_q      <= 1'b0;
`ifdef FENCE_SEQ_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end
        S_DRAIN: begin
          if (kill_i) begin
            state_q <= S_IDLE;
            out_q   <= decode(S_IDLE);
          end else if (sb_empty_i) begin
            state_q <= drain_exit;
            out_q   <= decode(drain_exit);
`ifdef FENCE_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_DFLUSH: begin
          // A kill cannot abandon the D$ handshake; it only redirects the exit.
          if (kill_i) kill_q <= 1'b1;
`ifdef FENCE_SEQ_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_q) begin
            state_q <= to_exit;
            out_q   <= decode(to_exit);
          end else if (flush_dcache_ack_i) begin
            state_q <= ack_exit;
            out_q   <= decode(ack_exit);
          end else if (cnt_q == CNT_LAST) begin
            timeout_q          <= 1'b1;
            out_q.flush_dcache <= 1'b0;
          end
`else
          if (flush_dcache_ack_i) begin
            state_q <= ack_exit;
            out_q   <= decode(ack_exit);
          end
`endif
        end
        S_IFLUSH: begin
          state_q <= kill_i ? S_IDLE : S_DONE;
          out_q   <= decode(kill_i ? S_IDLE : S_DONE);
        end
        S_DONE: begin
          state_q <= S_IDLE;
          out_q   <= decode(S_IDLE);
        end
        default: begin
          state_q <= S_IDLE;
          out_q   <= decode(S_IDLE);
        end
      endcase
    end
  end

  assign flush_dcache_o  = out_q.flush_dcache;
  assign flush_icache_o  = out_q.flush_icache;
  assign set_pc_commit_o = out_q.set_pc;
  assign flush_pipe_o    = out_q.flush_pipe;
  assign halt_o          = out_q.halt;
  assign busy_o          = out_q.busy;
`ifdef FENCE_SEQ_TIMEOUT_EN
  assign timeout_o       = timeout_q;
`else
  assign timeout_o       = 1'b0;
`endif

  // Commit is halted while busy, so a new fence committing now is illegal.
  a_no_fence_while_busy : assert property (
    @(posedge clk_i) disable iff (rst_i) busy_o |-> !(fence_i || fence_i_i));

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Bench for fence_flush_sequencer: directed and randomized sequences checked against
// a phase-timeline model built from the sequencing rules.
module tb_fence_flush_sequencer;

  localparam int TO = 8;

  typedef enum int {P_IDLE, P_DRAIN, P_DF, P_DF_TO, P_IF, P_DONE} phase_e;

  logic clk_i = 1'b0;
  logic rst_i;
  logic kill_i, sb_empty_i, ack_i;
  logic fence_a, fence_i_a, fence_b, fence_i_b;
  logic fd_a, fi_a, spc_a, fp_a, halt_a, busy_a, to_a;
  logic fd_b, fi_b, spc_b, fp_b, halt_b, busy_b, to_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit to_flag [2];

  phase_e ph_q[$];
  bit     sb_q[$], ack_q[$], kl_q[$], to_q[$];

  always #5 clk_i = ~clk_i;

  fence_flush_sequencer #(.SKIP_DCACHE_FLUSH(1'b0), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fence_i(fence_a), .fence_i_i(fence_i_a),
    .kill_i(kill_i), .sb_empty_i(sb_empty_i), .flush_dcache_o(fd_a),
    .flush_dcache_ack_i(ack_i), .flush_icache_o(fi_a), .set_pc_commit_o(spc_a),
    .flush_pipe_o(fp_a), .halt_o(halt_a), .busy_o(busy_a), .timeout_o(to_a));

  fence_flush_sequencer #(.SKIP_DCACHE_FLUSH(1'b1), .TIMEOUT_CYCLES(TO)) dut_skip (
    .clk_i(clk_i), .rst_i(rst_i), .fence_i(fence_b), .fence_i_i(fence_i_b),
    .kill_i(kill_i), .sb_empty_i(sb_empty_i), .flush_dcache_o(fd_b),
    .flush_dcache_ack_i(ack_i), .flush_icache_o(fi_b), .set_pc_commit_o(spc_b),
    .flush_pipe_o(fp_b), .halt_o(halt_b), .busy_o(busy_b), .timeout_o(to_b));

  function automatic logic [6:0] obs(input int which);
    if (which == 0) return {busy_a, halt_a, fd_a, fi_a, spc_a, fp_a, to_a};
    return {busy_b, halt_b, fd_b, fi_b, spc_b, fp_b, to_b};
  endfunction

  // Expected {busy, halt, flush_dcache, flush_icache, set_pc, flush_pipe, timeout}
  function automatic logic [6:0] expect_of(input phase_e p, input bit to);
    bit act;
    act = (p != P_IDLE);
    return {act, act, p == P_DF, p == P_IF, p == P_DONE, p == P_DONE, to};
  endfunction

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (busy halt fd fi spc fp to)", tag, observed, expected);
    end
  endtask

  task automatic push(input int which, input phase_e p, input bit sb, input bit ack, input bit kill);
    if (p == P_DF_TO) to_flag[which] = 1'b1;
    ph_q.push_back(p);
    sb_q.push_back(sb);
    ack_q.push_back(ack);
    kl_q.push_back(kill);
    to_q.push_back(to_flag[which]);
  endtask

  // One sequence: request at t=0, d cycles of non-empty store buffer, ack in
  // D$-flush cycle j (j<0: never), kill at absolute cycle kill_at (-1: none).
  task automatic run_txn(input string tag, input int which, input bit fencei, input bit both,
                         input int d, input int j, input int kill_at);
    bit killed, k, timed, req;
    killed = 1'b0;
    timed  = 1'b0;
    ph_q.delete(); sb_q.delete(); ack_q.delete(); kl_q.delete(); to_q.delete();
    push(which, P_IDLE, d == 0, 1'b0, 1'b0);
    to_flag[which] = 1'b0;
    for (int i = 0; i <= d; i++) begin
      k = (kill_at == ph_q.size());
      push(which, P_DRAIN, i == d, $urandom_range(0, 3) == 0, k);
      if (k) begin
        killed = 1'b1;
        break;
      end
    end
    if (!killed && which == 0) begin
      if (j < 0) begin
        for (int i = 0; i < TO; i++) begin
          k = (kill_at == ph_q.size());
          push(which, P_DF, 1'b1, 1'b0, k);
          killed |= k;
        end
        k = (kill_at == ph_q.size());
        push(which, P_DF_TO, 1'b1, 1'b1, k);
        killed |= k;
        timed = 1'b1;
      end else begin
        for (int i = 0; i <= j; i++) begin
          k = (kill_at == ph_q.size());
          push(which, P_DF, 1'b1, i == j, k);
          killed |= k;
        end
      end
    end
    if (!killed && fencei && !timed) begin
      k = (kill_at == ph_q.size());
      push(which, P_IF, 1'b1, $urandom_range(0, 1) == 1, k);
      killed = k;
    end
    if (!killed) push(which, P_DONE, 1'b1, $urandom_range(0, 1) == 1, kill_at == ph_q.size());
    for (int i = 0; i < 3; i++)
      push(which, P_IDLE, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    for (int t = 0; t < ph_q.size(); t++) begin
      @(posedge clk_i);
      #1;
      req        = (t == 0);
      fence_a    = (which == 0) && req && (!fencei || both);
      fence_i_a  = (which == 0) && req && fencei;
      fence_b    = (which == 1) && req && (!fencei || both);
      fence_i_b  = (which == 1) && req && fencei;
      sb_empty_i = sb_q[t];
      ack_i      = ack_q[t];
      kill_i     = kl_q[t];
      @(negedge clk_i);
      check($sformatf("%s t=%0d", tag, t), obs(which), expect_of(ph_q[t], to_q[t]));
    end
  endtask

  initial begin
    int which, d, j, ka;
    bit fi, bo;
    rst_i = 1'b1;
    fence_a = 1'b0; fence_i_a = 1'b0; fence_b = 1'b0; fence_i_b = 1'b0;
    kill_i = 1'b0; sb_empty_i = 1'b1; ack_i = 1'b0;
    to_flag[0] = 1'b0;
    to_flag[1] = 1'b0;
    #3;
    check("reset_main", obs(0), 7'b0);
    check("reset_skip", obs(1), 7'b0);
    @(negedge clk_i) rst_i = 1'b0;

    run_txn("fence_ack3",      0, 1'b0, 1'b0, 0, 2, -1);
    run_txn("fencei_sb5",      0, 1'b1, 1'b0, 5, 1, -1);
    run_txn("both_same_cycle", 0, 1'b1, 1'b1, 0, 1, -1);
    run_txn("fencei_latency",  0, 1'b1, 1'b0, 0, 1, -1);
    run_txn("kill_dflush",     0, 1'b1, 1'b0, 0, 4, 2);
    run_txn("kill_with_ack",   0, 1'b0, 1'b0, 1, 2, 5);
    run_txn("kill_beats_sb",   0, 1'b0, 1'b0, 2, 1, 3);
    run_txn("kill_iflush",     0, 1'b1, 1'b0, 0, 0, 3);
    run_txn("kill_done",       0, 1'b0, 1'b0, 0, 0, 3);
    run_txn("skip_fencei",     1, 1'b1, 1'b0, 0, 0, -1);
    run_txn("skip_fence",      1, 1'b0, 1'b0, 2, 0, -1);
    run_txn("skip_kill_if",    1, 1'b1, 1'b0, 1, 0, 3);
`ifdef FENCE_SEQ_TIMEOUT_EN
    run_txn("timeout",         0, 1'b1, 1'b0, 0, -1, -1);
    run_txn("timeout_clear",   0, 1'b0, 1'b0, 1, 2, -1);
    run_txn("timeout_kill",    0, 1'b1, 1'b0, 0, -1, 5);
`endif

    for (int n = 0; n < 30; n++) begin
      which = int'($urandom_range(0, 1));
      fi    = ($urandom_range(0, 1) == 1);
      bo    = fi && ($urandom_range(0, 1) == 1);
      d     = int'($urandom_range(0, 4));
      j     = int'($urandom_range(0, 5));
      ka    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1;
      run_txn($sformatf("rnd%0d", n), which, fi, bo, d, j, ka);
    end

    // Asynchronous reset while the main sequencer sits in the D$ flush.
    @(posedge clk_i);
    #1 fence_a = 1'b1; sb_empty_i = 1'b1; ack_i = 1'b0; kill_i = 1'b0;
    @(posedge clk_i);
    #1 fence_a = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_pre_dflush", obs(0), expect_of(P_DF, 1'b0));
    #1 rst_i = 1'b1;
    #1 check("rst_async_drop", obs(0), expect_of(P_IDLE, 1'b0));
    to_flag[0] = 1'b0;
    @(negedge clk_i) rst_i = 1'b0;
    @(negedge clk_i) check("rst_release_idle", obs(0), expect_of(P_IDLE, 1'b0));
    run_txn("after_reset", 0, 1'b1, 1'b0, 1, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
